// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and display constants for the sprite line engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam logic [4:0] ID_EMPTY = 5'd0;
    localparam int         H_ACTIVE = 640;
    localparam int         V_ACTIVE = 480;
    localparam int         V_TOTAL  = 525;

    typedef struct packed {
        logic [4:0] id;
        logic [8:0] y;
        logic [9:0] x;
    } sprite_entry_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SCAN  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_scheduler_if
//  Description : Sprite ROM fetch and line-buffer write bus of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_line_scheduler_if #(
    parameter int ROM_AW = 15
);
    logic [ROM_AW-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic              lb_we;
    logic              lb_bank;
    logic [9:0]        lb_addr;
    logic [23:0]       lb_data;

    modport master (
        output rom_addr,
        input  rom_data,
        output lb_we,
        output lb_bank,
        output lb_addr,
        output lb_data
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  lb_we,
        input  lb_bank,
        input  lb_addr,
        input  lb_data
    );
endinterface
`default_nettype wire

// File: rtl/sprite_line_scheduler_hit_test.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_hit_test
//  Description : Decides whether a sprite entry covers a given line and which
//                sprite row lands there.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_hit_test
    import sprite_pkg::*;
#(
    parameter int SPR_H = 32
) (
    input  wire sprite_entry_t             i_entry,
    input  wire logic [9:0]                i_target_line,
    output logic                           o_hit,
    output logic [$clog2(SPR_H)-1:0]       o_row
);
    logic [9:0] w_y;
    logic [9:0] w_y_end;

    // Plain 10-bit range test: sprites never wrap past the bottom of the frame.
    assign w_y     = {1'b0, i_entry.y};
    assign w_y_end = w_y + 10'(SPR_H);
    assign o_hit   = (i_entry.id != ID_EMPTY) &&
                     (i_target_line >= w_y) && (i_target_line < w_y_end);
    assign o_row   = i_target_line[$clog2(SPR_H)-1:0] - i_entry.y[$clog2(SPR_H)-1:0];

endmodule
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_scheduler
//  Description : Per-scanline fill sequencer: clears the back line-buffer bank,
//                scans the sprite table and streams hit sprite rows into it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int N_SPRITES = 20,
    parameter int SPR_W     = 32,
    parameter int SPR_H     = 32,
    parameter int H_ACTIVE  = sprite_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = sprite_pkg::V_ACTIVE,
    parameter int V_TOTAL   = sprite_pkg::V_TOTAL,
    parameter int ROM_AW    = 15
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic [9:0]                     VGA_HCOUNT,
    input  wire logic [9:0]                     VGA_VCOUNT,
    input  wire sprite_entry_t [N_SPRITES-1:0]  gl_array,
    sprite_line_scheduler_if.master             bus,
    output logic                                busy,
    output logic                                overrun
);
    localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam int ROW_W = $clog2(SPR_H);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_SPRITES - 1);

    fill_state_t        r_state;
    fill_state_t        w_state_next;
    logic               r_at_start;
    logic               w_at_start;
    logic               w_start;
    logic [9:0]         w_target;
    logic               w_target_valid;
    logic [9:0]         r_target;
    logic [9:0]         r_col;
    logic [9:0]         w_col_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               w_latch_target;
    logic               w_latch_entry;
    logic [4:0]         r_id;
    logic [9:0]         r_x;
    logic [ROW_W-1:0]   r_row;
    logic               r_overrun;
    sprite_entry_t      w_entry;
    logic               w_hit;
    logic [ROW_W-1:0]   w_row;
    logic [10:0]        w_draw_col;

    // HCOUNT holds each value for two clocks; only the first one starts a fill.
    assign w_at_start     = (VGA_HCOUNT == 10'(H_ACTIVE));
    assign w_start        = w_at_start && !r_at_start;
    assign w_target       = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 10'd0 : VGA_VCOUNT + 10'd1;
    assign w_target_valid = (w_target < 10'(V_ACTIVE));
    assign w_entry        = gl_array[r_idx];

    // r_col runs one past the last column so the trailing ROM word gets written.
    assign w_draw_col     = 11'(r_x) + 11'(r_col) - 11'd1;

    sprite_hit_test #(
        .SPR_H (SPR_H)
    ) u_hit_test (
        .i_entry       (w_entry),
        .i_target_line (r_target),
        .o_hit         (w_hit),
        .o_row         (w_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_at_start <= 1'b0;
            r_target   <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_id       <= '0;
            r_x        <= '0;
            r_row      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_at_start <= w_at_start;
            r_col      <= w_col_next;
            r_idx      <= w_idx_next;
            if (w_latch_target) begin
                r_target <= w_target;
            end
            if (w_latch_entry) begin
                r_id  <= w_entry.id;
                r_x   <= w_entry.x;
                r_row <= w_row;
            end
            if (w_start && busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_col_next     = r_col;
        w_idx_next     = r_idx;
        w_latch_target = 1'b0;
        w_latch_entry  = 1'b0;
        busy           = 1'b0;
        bus.rom_addr   = '0;
        bus.lb_we      = 1'b0;
        bus.lb_bank    = r_target[0];
        bus.lb_addr    = '0;
        bus.lb_data    = '0;

        case (r_state)
            IDLE: begin
            end
            CLEAR: begin
                busy        = 1'b1;
                bus.lb_we   = 1'b1;
                bus.lb_addr = r_col;
                if (r_col == 10'(H_ACTIVE - 1)) begin
                    w_state_next = SCAN;
                    w_idx_next   = c_last_idx;
                end else begin
                    w_col_next = r_col + 10'd1;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (w_hit) begin
                    w_state_next  = DRAW;
                    w_col_next    = '0;
                    w_latch_entry = 1'b1;
                end else if (r_idx == '0) begin
                    w_state_next = DONE;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            DRAW: begin
                busy = 1'b1;
                if (r_col < 10'(SPR_W)) begin
                    bus.rom_addr = ROM_AW'((32'(r_id) * 32'(SPR_H) + 32'(r_row)) * 32'(SPR_W)
                                           + 32'(r_col));
                end
                // Transparent pixels and columns past the right edge are dropped.
                if ((r_col != '0) && (w_draw_col < 11'(H_ACTIVE)) && (bus.rom_data != 24'h0)) begin
                    bus.lb_we   = 1'b1;
                    bus.lb_addr = w_draw_col[9:0];
                    bus.lb_data = bus.rom_data;
                end
                if (r_col == 10'(SPR_W)) begin
                    if (r_idx == '0) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = SCAN;
                        w_idx_next   = r_idx - 1'b1;
                    end
                end else begin
                    w_col_next = r_col + 10'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A new line always wins: abandon whatever is in flight.
        if (w_start) begin
            if (w_target_valid) begin
                w_state_next   = CLEAR;
                w_col_next     = '0;
                w_latch_target = 1'b1;
            end else begin
                w_state_next = IDLE;
            end
        end
    end

    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_line_scheduler
//  Description : Self-checking bench comparing line-buffer fills against a
//                painter's-algorithm reference of the sprite table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_scheduler;
    import sprite_pkg::*;

    localparam int N  = 20;
    localparam int SW = 32;
    localparam int SH = 32;
    localparam int HA = 640;
    localparam int VA = 480;
    localparam int VT = 525;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [9:0]             hcount = '0;
    logic [9:0]             vcount = '0;
    sprite_entry_t [N-1:0]  table_r;
    logic                   busy;
    logic                   overrun;
    int                     rom_mode = 0;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt, busy_cyc, bad_wr, clear_bad;
    logic        exp_bank;
    int          exp_hits, exp_opaque;
    logic [23:0] lb_mem [2][HA];
    logic [23:0] exp_line [HA];

    sprite_line_scheduler_if #(.ROM_AW(15)) bus ();

    sprite_line_scheduler #(
        .N_SPRITES (N),
        .SPR_W     (SW),
        .SPR_H     (SH),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .V_TOTAL   (VT),
        .ROM_AW    (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .VGA_HCOUNT (hcount),
        .VGA_VCOUNT (vcount),
        .gl_array   (table_r),
        .bus        (bus),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix_fn(input int id, input int row, input int col, input int mode);
        logic [23:0] p;
        p = {1'b1, 7'(id), 8'(row), 8'(col)};
        if (mode == 1 && (col % 2) == 0) p = '0;
        if (mode == 2 && ((id + 3 * row + 7 * col) % 5) == 0) p = '0;
        return p;
    endfunction

    // Registered ROM: decodes the address back into sprite/row/column.
    always @(posedge clk) begin
        bus.rom_data <= pix_fn(int'(bus.rom_addr) / (SW * SH),
                               (int'(bus.rom_addr) / SW) % SH,
                               int'(bus.rom_addr) % SW, rom_mode);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (busy === 1'b1) busy_cyc++;
        if (bus.lb_we === 1'b1) begin
            if (bus.lb_addr >= 10'(HA) || bus.lb_bank !== exp_bank) bad_wr++;
            else lb_mem[bus.lb_bank][bus.lb_addr] = bus.lb_data;
            if (wr_cnt < HA && (bus.lb_addr != 10'(wr_cnt) || bus.lb_data != 24'h0)) clear_bad++;
            wr_cnt++;
        end
    endtask

    // Painter's order: highest index first, so index 0 ends up on top.
    task automatic model(input int target, input int mode);
        int id, y, x;
        logic [23:0] p;
        exp_hits = 0;
        exp_opaque = 0;
        for (int c = 0; c < HA; c++) exp_line[c] = 24'h0;
        for (int i = N - 1; i >= 0; i--) begin
            id = int'(table_r[i].id);
            y  = int'(table_r[i].y);
            x  = int'(table_r[i].x);
            if (id != 0 && target >= y && target < y + SH) begin
                exp_hits++;
                for (int c = 0; c < SW; c++) begin
                    p = pix_fn(id, target - y, c, mode);
                    if (p != 24'h0 && x + c < HA) begin
                        exp_line[x + c] = p;
                        exp_opaque++;
                    end
                end
            end
        end
    endtask

    function automatic int target_of(input int v);
        return (v == VT - 1) ? 0 : v + 1;
    endfunction

    task automatic begin_fill(input int v);
        int t;
        t = target_of(v);
        wr_cnt = 0;
        busy_cyc = 0;
        bad_wr = 0;
        clear_bad = 0;
        exp_bank = t[0];
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < HA; c++) lb_mem[b][c] = 24'hDEAD01;
        vcount = 10'(v);
        hcount = 10'(HA);
        step();
        step();
        hcount = 10'(HA + 1);
    endtask

    task automatic verify(input string tag, input int v, input logic exp_ovr);
        int t, mism, n;
        logic valid;
        t = target_of(v);
        valid = (t < VA);
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            step();
            n++;
        end
        check({tag, ".idle"}, 64'(busy), 64'(0));
        check({tag, ".busy_cycles"}, 64'(busy_cyc), valid ? 64'(HA + N + exp_hits * (SW + 1)) : 64'(0));
        check({tag, ".writes"}, 64'(wr_cnt), valid ? 64'(HA + exp_opaque) : 64'(0));
        check({tag, ".bad_writes"}, 64'(bad_wr), 64'(0));
        check({tag, ".clear_seq"}, 64'(clear_bad), 64'(0));
        mism = 0;
        if (valid) begin
            for (int c = 0; c < HA; c++)
                if (lb_mem[t % 2][c] !== exp_line[c]) mism++;
        end
        check({tag, ".line_mismatch"}, 64'(mism), 64'(0));
        check({tag, ".overrun"}, 64'(overrun), 64'(exp_ovr));
        step();
        step();
    endtask

    task automatic do_fill(input string tag, input int v, input int mode);
        rom_mode = mode;
        model(target_of(v), mode);
        begin_fill(v);
        verify(tag, v, 1'b0);
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) table_r[i] = '0;
    endtask

    task automatic set_entry(input int i, input int id, input int x, input int y);
        table_r[i].id = 5'(id);
        table_r[i].x  = 10'(x);
        table_r[i].y  = 9'(y);
    endtask

    initial begin
        int t, y;
        clear_table();
        exp_bank = 1'b0;
        wr_cnt = 0; busy_cyc = 0; bad_wr = 0; clear_bad = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.overrun", 64'(overrun), 64'(0));
        check("reset.lb_we", 64'(bus.lb_we), 64'(0));
        check("reset.lb_bank", 64'(bus.lb_bank), 64'(0));
        check("reset.lb_addr", 64'(bus.lb_addr), 64'(0));
        check("reset.lb_data", 64'(bus.lb_data), 64'(0));
        check("reset.rom_addr", 64'(bus.rom_addr), 64'(0));

        // Single sprite, row 10 lands on line 60.
        set_entry(3, 2, 100, 50);
        do_fill("single", 59, 0);

        // Overlap: entry 0 must end up on top of entry 5.
        clear_table();
        set_entry(0, 3, 200, 100);
        set_entry(5, 9, 200, 100);
        do_fill("overlap", 110, 0);
        check("overlap.col200", 64'(lb_mem[1][200]), 64'(pix_fn(3, 11, 0, 0)));

        // Right-edge clipping, opaque then every other column transparent.
        clear_table();
        set_entry(7, 4, 620, 10);
        do_fill("clip", 20, 0);
        check("clip.writes20", 64'(wr_cnt - HA), 64'(20));
        do_fill("clip_odd", 20, 1);
        check("clip_odd.writes10", 64'(wr_cnt - HA), 64'(10));

        // Last visible line has nothing below it; last frame line wraps to 0.
        clear_table();
        set_entry(7, 5, 10, 0);
        do_fill("vcount479", 479, 0);
        do_fill("vcount524", 524, 0);

        // Restart while drawing entry 19.
        clear_table();
        set_entry(19, 4, 300, 200);
        rom_mode = 0;
        begin_fill(205);
        repeat (650) step();
        check("overrun.pre_draw_busy", 64'(busy), 64'(1));
        model(target_of(210), 0);
        begin_fill(210);
        check("overrun.sticky", 64'(overrun), 64'(1));
        check("overrun.bank", 64'(bus.lb_bank), 64'(1));
        verify("overrun", 210, 1'b1);

        // Reset while drawing.
        begin_fill(205);
        repeat (650) step();
        reset = 1'b1;
        step();
        check("rst_mid.lb_we", 64'(bus.lb_we), 64'(0));
        check("rst_mid.busy", 64'(busy), 64'(0));
        check("rst_mid.overrun", 64'(overrun), 64'(0));
        reset = 1'b0;
        wr_cnt = 0;
        repeat (50) step();
        check("rst_mid.no_writes", 64'(wr_cnt), 64'(0));

        // Worst case: every entry hits the same line.
        clear_table();
        for (int i = 0; i < N; i++) set_entry(i, i + 1, i * 30, 100);
        do_fill("all20", 110, 0);
        check("all20.total", 64'(busy_cyc), 64'(1320));

        // Randomized tables around a random target line.
        for (int it = 0; it < 8; it++) begin
            int v;
            v = int'($urandom_range(0, VT - 1));
            t = target_of(v);
            for (int i = 0; i < N; i++) begin
                y = t - int'($urandom_range(0, 40));
                if (y < 0) y = 0;
                if (y > 511) y = 511;
                set_entry(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                          int'($urandom_range(0, 660)), y);
            end
            do_fill($sformatf("rand%0d", it), v, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
